// File: rtl/pan_tilt_scheduler_pkg.sv
// pan_tilt_scheduler_pkg
// Shared definitions for the pan/tilt scheduler: FSM state encoding,
// coordinate and fixture-index widths, and the lowest-set-bit helper used
// to walk the per-frame fixture mask in index order.
package pan_tilt_scheduler_pkg;

  localparam int X_W        = 11;  // tracked / fixture x coordinate width
  localparam int Y_W        = 10;  // tracked / fixture y coordinate width
  localparam int IDX_W      = 2;   // fixture index width
  localparam int MAX_LIGHTS = 4;   // table capacity addressable by IDX_W

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_SETUP_WAIT = 3'd2,
    ST_DIV_START  = 3'd3,
    ST_DIV_WAIT   = 3'd4,
    ST_EMIT       = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  // Index of the lowest set bit; 0 when the mask is empty (callers check
  // for an empty mask separately).
  function automatic logic [IDX_W-1:0] first_set(input logic [MAX_LIGHTS-1:0] m);
    first_set = '0;
    for (int i = MAX_LIGHTS - 1; i >= 0; i--) begin
      if (m[i]) first_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/pan_tilt_scheduler_light_table.sv
// pan_tilt_scheduler_light_table
// Fixture table: NUM_LIGHTS entries of {x, y, en}. Synchronous write,
// asynchronous read, synchronous clear on reset.
// Ports:
//   clk, reset          clock, synchronous active-high clear
//   we/waddr/wx/wy/wen  write port (ignored for addresses >= NUM_LIGHTS)
//   raddr -> rx/ry      combinational read of one entry
//   en_mask             enable bit of every entry (unused bits read 0)
module pan_tilt_scheduler_light_table
  import pan_tilt_scheduler_pkg::*;
#(
  parameter int NUM_LIGHTS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [X_W-1:0]        wx,
  input  logic [Y_W-1:0]        wy,
  input  logic                  wen,
  input  logic [IDX_W-1:0]      raddr,
  output logic [X_W-1:0]        rx,
  output logic [Y_W-1:0]        ry,
  output logic [MAX_LIGHTS-1:0] en_mask
);

  logic [X_W-1:0]        x_mem [NUM_LIGHTS];
  logic [Y_W-1:0]        y_mem [NUM_LIGHTS];
  logic [NUM_LIGHTS-1:0] en_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LIGHTS; i++) begin
        x_mem[i] <= '0;
        y_mem[i] <= '0;
      end
      en_mem <= '0;
    end else if (we && (int'(waddr) < NUM_LIGHTS)) begin
      x_mem[waddr]  <= wx;
      y_mem[waddr]  <= wy;
      en_mem[waddr] <= wen;
    end
  end

  always_comb begin
    rx      = '0;
    ry      = '0;
    en_mask = '0;
    if (int'(raddr) < NUM_LIGHTS) begin
      rx = x_mem[raddr];
      ry = y_mem[raddr];
    end
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      en_mask[i] = en_mem[i];
    end
  end

endmodule

// File: rtl/pan_tilt_scheduler.sv
// pan_tilt_scheduler
// Sequences the shared pan/tilt setup stage and normalizing divider across
// up to NUM_LIGHTS DMX fixtures once per video frame. On frame_done the
// tracked centre of mass and the fixture enable mask are latched; enabled
// fixtures are then visited in index order: operands are presented to the
// setup stage, SETUP_LATENCY cycles are waited out, the divider is started
// and, on div_done, a tagged result strobe is emitted.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   frame_done, x_com, y_com       tracked point, valid on frame_done pulse
//   cfg_we/cfg_addr/cfg_x/cfg_y/cfg_en   fixture-table write port
//   setup_x_com/setup_y_com/setup_x_light/setup_y_light  operands to setup stage
//   x_greater_than_y               setup-stage comparison result
//   div_start / div_done           divider handshake
//   result_valid/result_light/result_xgty  per-fixture result strobe
//   frame_complete                 all enabled fixtures of a frame done
//   busy                           scheduler not idle
//   overrun                        sticky: a pending frame was overwritten
//   div_error                      sticky divider timeout (DIV_TIMEOUT_EN only)
// Build option: define DIV_TIMEOUT_EN to abort a fixture whose divider does
// not answer within DIV_TIMEOUT cycles and expose the div_error port.
module pan_tilt_scheduler
  import pan_tilt_scheduler_pkg::*;
#(
  parameter int NUM_LIGHTS    = 4,
  parameter int SETUP_LATENCY = 2,
  parameter int DIV_TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_done,
  input  logic [X_W-1:0]   x_com,
  input  logic [Y_W-1:0]   y_com,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [X_W-1:0]   cfg_x,
  input  logic [Y_W-1:0]   cfg_y,
  input  logic             cfg_en,
  output logic [X_W-1:0]   setup_x_com,
  output logic [Y_W-1:0]   setup_y_com,
  output logic [X_W-1:0]   setup_x_light,
  output logic [Y_W-1:0]   setup_y_light,
  input  logic             x_greater_than_y,
  output logic             div_start,
  input  logic             div_done,
  output logic             result_valid,
  output logic [IDX_W-1:0] result_light,
  output logic             result_xgty,
  output logic             frame_complete,
  output logic             busy,
  output logic             overrun
`ifdef DIV_TIMEOUT_EN
  ,
  output logic             div_error
`endif
);

  // Shared down/up counter: setup latency countdown, then divider wait time.
  localparam int CNT_W = $clog2(DIV_TIMEOUT + SETUP_LATENCY + 1) + 1;

  state_t                state;
  logic [MAX_LIGHTS-1:0] frame_mask;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      next_idx;
  logic [CNT_W-1:0]      cnt;
  logic                  xgty_cap;
  logic                  empty_hold;
  logic                  pend_vld;
  logic [X_W-1:0]        com_x;
  logic [Y_W-1:0]        com_y;
  logic [X_W-1:0]        pend_x;
  logic [Y_W-1:0]        pend_y;
  logic [X_W-1:0]        tbl_x;
  logic [Y_W-1:0]        tbl_y;
  logic [MAX_LIGHTS-1:0] tbl_en;

  pan_tilt_scheduler_light_table #(
    .NUM_LIGHTS(NUM_LIGHTS)
  ) u_light_table (
    .clk     (clk),
    .reset   (reset),
    .we      (cfg_we),
    .waddr   (cfg_addr),
    .wx      (cfg_x),
    .wy      (cfg_y),
    .wen     (cfg_en),
    .raddr   (next_idx),
    .rx      (tbl_x),
    .ry      (tbl_y),
    .en_mask (tbl_en)
  );

  assign next_idx = first_set(frame_mask);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      frame_mask     <= '0;
      idx            <= '0;
      cnt            <= '0;
      xgty_cap       <= 1'b0;
      empty_hold     <= 1'b0;
      pend_vld       <= 1'b0;
      setup_x_com    <= '0;
      setup_y_com    <= '0;
      setup_x_light  <= '0;
      setup_y_light  <= '0;
      div_start      <= 1'b0;
      result_valid   <= 1'b0;
      result_light   <= '0;
      result_xgty    <= 1'b0;
      frame_complete <= 1'b0;
      overrun        <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      div_error      <= 1'b0;
`endif
    end else begin
      div_start      <= 1'b0;
      result_valid   <= 1'b0;
      frame_complete <= 1'b0;

      // A frame arriving mid-sequence parks in the one-deep pending slot;
      // DONE handles its own arrival because it consumes the slot directly.
      if (frame_done && (state != ST_IDLE) && (state != ST_DONE)) begin
        pend_x   <= x_com;
        pend_y   <= y_com;
        pend_vld <= 1'b1;
        if (pend_vld) overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (frame_done) begin
            com_x      <= x_com;
            com_y      <= y_com;
            frame_mask <= tbl_en;
            state      <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (frame_mask == '0) begin
            // An empty frame lingers one extra cycle here so its
            // frame_complete lands three cycles after frame_done.
            if (!empty_hold) begin
              empty_hold <= 1'b1;
            end else begin
              empty_hold     <= 1'b0;
              frame_complete <= 1'b1;
              state          <= ST_DONE;
            end
          end else begin
            idx                  <= next_idx;
            setup_x_com          <= com_x;
            setup_y_com          <= com_y;
            setup_x_light        <= tbl_x;
            setup_y_light        <= tbl_y;
            frame_mask[next_idx] <= 1'b0;
            cnt                  <= CNT_W'(SETUP_LATENCY);
            state                <= ST_SETUP_WAIT;
          end
        end

        ST_SETUP_WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            div_start <= 1'b1;
            state     <= ST_DIV_START;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_DIV_START: begin
          // Setup outputs are valid now; div_done this cycle is not ours.
          xgty_cap <= x_greater_than_y;
          cnt      <= '0;
          state    <= ST_DIV_WAIT;
        end

        ST_DIV_WAIT: begin
          if (div_done) begin
            result_valid <= 1'b1;
            result_light <= idx;
            result_xgty  <= xgty_cap;
            state        <= ST_EMIT;
          end
`ifdef DIV_TIMEOUT_EN
          else if (cnt == CNT_W'(DIV_TIMEOUT - 1)) begin
            // Give up on this fixture and carry on as if it had emitted.
            div_error <= 1'b1;
            if (frame_mask != '0) begin
              state <= ST_LOAD;
            end else begin
              frame_complete <= 1'b1;
              state          <= ST_DONE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end

        ST_EMIT: begin
          if (frame_mask != '0) begin
            state <= ST_LOAD;
          end else begin
            frame_complete <= 1'b1;
            state          <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (pend_vld || frame_done) begin
            // A frame_done arriving right now is the newest point.
            com_x      <= frame_done ? x_com : pend_x;
            com_y      <= frame_done ? y_com : pend_y;
            frame_mask <= tbl_en;
            pend_vld   <= 1'b0;
            if (frame_done && pend_vld) overrun <= 1'b1;
            state      <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pan_tilt_scheduler.sv
module tb_pan_tilt_scheduler;

  logic        clk;
  logic        reset;
  logic        frame_done;
  logic [10:0] x_com;
  logic [9:0]  y_com;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [10:0] cfg_x;
  logic [9:0]  cfg_y;
  logic        cfg_en;
  logic [10:0] setup_x_com;
  logic [9:0]  setup_y_com;
  logic [10:0] setup_x_light;
  logic [9:0]  setup_y_light;
  logic        x_greater_than_y;
  logic        div_start;
  logic        div_done;
  logic        result_valid;
  logic [1:0]  result_light;
  logic        result_xgty;
  logic        frame_complete;
  logic        busy;
  logic        overrun;
`ifdef DIV_TIMEOUT_EN
  logic        div_error;
`endif

  pan_tilt_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .frame_done       (frame_done),
    .x_com            (x_com),
    .y_com            (y_com),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_x            (cfg_x),
    .cfg_y            (cfg_y),
    .cfg_en           (cfg_en),
    .setup_x_com      (setup_x_com),
    .setup_y_com      (setup_y_com),
    .setup_x_light    (setup_x_light),
    .setup_y_light    (setup_y_light),
    .x_greater_than_y (x_greater_than_y),
    .div_start        (div_start),
    .div_done         (div_done),
    .result_valid     (result_valid),
    .result_light     (result_light),
    .result_xgty      (result_xgty),
    .frame_complete   (frame_complete),
    .busy             (busy),
    .overrun          (overrun)
`ifdef DIV_TIMEOUT_EN
    ,
    .div_error        (div_error)
`endif
  );

  // Stand-in for the setup stage's comparison output.
  assign x_greater_than_y = (setup_x_light > setup_x_com);

  typedef struct {
    logic [1:0]  idx;
    logic        xgty;
    logic [10:0] lx;
    logic [9:0]  ly;
    logic [10:0] cx;
    int          cyc;
  } rv_t;

  rv_t rv_q[$];
  int  ds_q[$];
  int  fc_q[$];
  int  extra_rv, extra_ds, extra_fc;
  int  total, bad;
  int  cyc;
  int  div_delay;
  logic div_auto;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Divider model: div_done pulses div_delay cycles after div_start.
  initial begin
    div_done = 1'b0;
    forever begin
      @(negedge clk);
      if (div_start && div_auto) begin
        repeat (div_delay) @(negedge clk);
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
      end
    end
  end

  // Scoreboard: pop expectations as the DUT produces strobes.
  initial begin
    extra_rv = 0; extra_ds = 0; extra_fc = 0;
    forever begin
      @(negedge clk);
      if (div_start === 1'b1) begin
        if (ds_q.size() == 0) extra_ds++;
        else check("div_start_cycle", cyc, ds_q.pop_front());
      end
      if (frame_complete === 1'b1) begin
        if (fc_q.size() == 0) extra_fc++;
        else check("frame_complete_cycle", cyc, fc_q.pop_front());
      end
      if (result_valid === 1'b1) begin
        if (rv_q.size() == 0) extra_rv++;
        else begin
          rv_t e;
          e = rv_q.pop_front();
          check("result_cycle", cyc, e.cyc);
          check("result_light", 32'(result_light), 32'(e.idx));
          check("result_xgty", 32'(result_xgty), 32'(e.xgty));
          check("result_x_light", 32'(setup_x_light), 32'(e.lx));
          check("result_y_light", 32'(setup_y_light), 32'(e.ly));
          check("result_x_com", 32'(setup_x_com), 32'(e.cx));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

  task automatic push_rv(input logic [1:0] idx, input logic xgty, input logic [10:0] lx,
                         input logic [9:0] ly, input logic [10:0] cx, input int c);
    rv_t e;
    e.idx = idx; e.xgty = xgty; e.lx = lx; e.ly = ly; e.cx = cx; e.cyc = c;
    rv_q.push_back(e);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [10:0] x, input logic [9:0] y, input logic en);
    cfg_we = 1'b1; cfg_addr = a; cfg_x = x; cfg_y = y; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_frame(input logic [10:0] x, input logic [9:0] y, output int t);
    frame_done = 1'b1; x_com = x; y_com = y;
    t = cyc;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_results_left"}, rv_q.size(), 0);
    check({tag, "_starts_left"}, ds_q.size(), 0);
    check({tag, "_completes_left"}, fc_q.size(), 0);
  endtask

  initial begin
    int t;
    total = 0; bad = 0;
    reset = 1'b1; frame_done = 1'b0; x_com = '0; y_com = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
    div_auto = 1'b1; div_delay = 5;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_div_start", 32'(div_start), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_frame_complete", 32'(frame_complete), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_x_light", 32'(setup_x_light), 0);
    check("rst_x_com", 32'(setup_x_com), 0);
    check("rst_result_light", 32'(result_light), 0);
`ifdef DIV_TIMEOUT_EN
    check("rst_div_error", 32'(div_error), 0);
`endif

    // Fixtures 0 and 2 enabled
    cfg_write(2'd0, 11'd100, 10'd50, 1'b1);
    cfg_write(2'd2, 11'd700, 10'd400, 1'b1);
    start_frame(11'd320, 10'd240, t);
    push_rv(2'd0, 1'b0, 11'd100, 10'd50, 11'd320, t + 10);
    push_rv(2'd2, 1'b1, 11'd700, 10'd400, 11'd320, t + 20);
    ds_q.push_back(t + 4); ds_q.push_back(t + 14);
    fc_q.push_back(t + 21);
    wait_idle("two_fixtures");

    // No fixtures enabled
    cfg_write(2'd0, 11'd100, 10'd50, 1'b0);
    cfg_write(2'd2, 11'd700, 10'd400, 1'b0);
    start_frame(11'd320, 10'd240, t);
    fc_q.push_back(t + 3);
    wait_idle("empty_frame");

    // Two frame_done pulses while busy: last one wins, overrun set
    cfg_write(2'd0, 11'd100, 10'd50, 1'b1);
    start_frame(11'd320, 10'd240, t);
    push_rv(2'd0, 1'b0, 11'd100, 10'd50, 11'd320, t + 10);
    push_rv(2'd0, 1'b1, 11'd100, 10'd50, 11'd30, t + 21);
    ds_q.push_back(t + 4); ds_q.push_back(t + 15);
    fc_q.push_back(t + 11); fc_q.push_back(t + 22);
    check("ovr_before", 32'(overrun), 0);
    frame_done = 1'b1; x_com = 11'd10; y_com = 10'd20;
    @(negedge clk);
    x_com = 11'd30; y_com = 10'd40;
    @(negedge clk);
    frame_done = 1'b0;
    check("ovr_set", 32'(overrun), 1);
    wait_idle("overrun");
    check("ovr_sticky", 32'(overrun), 1);

    // Table write during DIV_WAIT does not disturb current operands
    cfg_write(2'd0, 11'd100, 10'd50, 1'b0);
    cfg_write(2'd1, 11'd500, 10'd300, 1'b1);
    start_frame(11'd320, 10'd240, t);
    push_rv(2'd1, 1'b1, 11'd500, 10'd300, 11'd320, t + 10);
    ds_q.push_back(t + 4);
    fc_q.push_back(t + 11);
    repeat (5) @(negedge clk);
    cfg_write(2'd1, 11'd900, 10'd300, 1'b1);
    check("cfg_hold_x_light", 32'(setup_x_light), 500);
    wait_idle("cfg_mid_frame");
    start_frame(11'd320, 10'd240, t);
    push_rv(2'd1, 1'b1, 11'd900, 10'd300, 11'd320, t + 10);
    ds_q.push_back(t + 4);
    fc_q.push_back(t + 11);
    wait_idle("cfg_next_frame");

    // Reset while in DIV_WAIT
    start_frame(11'd320, 10'd240, t);
    ds_q.push_back(t + 4);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_x_light", 32'(setup_x_light), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    repeat (12) @(negedge clk);
    check("mid_rst_busy_later", 32'(busy), 0);
    check("mid_rst_starts_left", ds_q.size(), 0);

`ifdef DIV_TIMEOUT_EN
    // Divider never answers: both fixtures time out, frame still completes
    div_auto = 1'b0;
    cfg_write(2'd0, 11'd100, 10'd50, 1'b1);
    cfg_write(2'd3, 11'd5, 10'd6, 1'b1);
    start_frame(11'd320, 10'd240, t);
    ds_q.push_back(t + 4); ds_q.push_back(t + 72);
    fc_q.push_back(t + 137);
    repeat (67) @(negedge clk);
    check("timeout_err_before", 32'(div_error), 0);
    @(negedge clk);
    check("timeout_err_set", 32'(div_error), 1);
    wait_idle("timeout");
    check("timeout_err_sticky", 32'(div_error), 1);
`endif

    check("unexpected_results", extra_rv, 0);
    check("unexpected_div_starts", extra_ds, 0);
    check("unexpected_frame_completes", extra_fc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pan_tilt_scheduler.md
# pan_tilt_scheduler

Sequences the shared pan/tilt arithmetic datapath (setup stage plus normalizing divider) across up to four DMX fixtures once per video frame. On each centre-of-mass update it latches the tracked point, walks the enabled fixtures in index order, presents each fixture's position to the setup stage, waits out its pipeline latency, starts the shared divider, and reports a tagged result strobe per fixture. It sits between the video tracker and the DMX channel formatter.

## Interface
- NUM_LIGHTS, 4, fixtures scheduled (1–4; index width 2)
- SETUP_LATENCY, 2, setup-stage cycles from operand change to valid outputs
- DIV_TIMEOUT, 64, max DIV_WAIT cycles before abort (used only with DIV_TIMEOUT_EN)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_done  in  1  one-cycle pulse: x_com/y_com valid
- x_com  in  11  tracked x; y_com  in  10  tracked y
- cfg_we  in  1  fixture-table write; cfg_addr  in  2; cfg_x  in  11; cfg_y  in  10; cfg_en  in  1  fixture enable
- setup_x_com  out  11; setup_y_com  out  10; setup_x_light  out  11; setup_y_light  out  10  registered operands to setup stage
- x_greater_than_y  in  1  from setup stage
- div_start  out  1  one-cycle divider start pulse
- div_done  in  1  divider result valid pulse
- result_valid  out  1  one-cycle: fixture result complete
- result_light  out  2  fixture index of result
- result_xgty  out  1  x_greater_than_y captured for that fixture
- frame_complete  out  1  one-cycle: all enabled fixtures done
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky: frame_done arrived with one already pending

## Operation
- States: IDLE, LOAD, SETUP_WAIT, DIV_START, DIV_WAIT, EMIT, DONE.
- Fixture table: NUM_LIGHTS entries {x, y, en}; cfg writes take effect any cycle; reset clears all to 0.
- IDLE + frame_done: latch x_com/y_com, latch frame_mask = enable bits -> LOAD.
- LOAD: idx = lowest set bit of frame_mask; register operands from table[idx]; clear bit; counter = SETUP_LATENCY -> SETUP_WAIT. If frame_mask == 0 -> DONE.
- SETUP_WAIT: decrement; at 1 -> DIV_START.
- DIV_START: div_start = 1; capture x_greater_than_y -> DIV_WAIT. div_done in this cycle ignored.
- DIV_WAIT: on div_done -> EMIT.
- EMIT: result_valid = 1, result_light = idx, result_xgty = captured; -> LOAD if frame_mask != 0, else DONE.
- DONE: frame_complete = 1; -> LOAD (relatching pending COM/mask) if pending, else IDLE.
- frame_done while busy: store COM into one-deep pending slot; if slot already full, overwrite and set overrun. frame_done in DONE cycle counts as pending.
- Table writes during a frame affect operands only at the next LOAD; frame_mask is not modified by cfg writes.
- Operands hold between fixtures (no glitch to zero).
- Reset mid-operation: -> IDLE, pending cleared, no result_valid/frame_complete emitted.

## Timing
- Reset values: all outputs 0; state IDLE.
- frame_done at cycle t (IDLE): LOAD at t+1, operands visible t+2, div_start at t+2+SETUP_LATENCY (t+4 default).
- div_done at cycle d: result_valid at d+1; next LOAD at d+2 or frame_complete at d+2.
- Per-fixture cost: 3 + SETUP_LATENCY + divider cycles.
- No enabled fixtures: frame_complete at t+3, no result_valid.

## Configuration
- DIV_TIMEOUT_EN defined: DIV_WAIT counts cycles; reaching DIV_TIMEOUT without div_done -> skip EMIT for that fixture, set sticky output div_error (1 bit, reset 0), proceed as after EMIT. A late div_done is ignored outside DIV_WAIT.
- Undefined: DIV_WAIT waits indefinitely; div_error port absent.

## Structure
- Shared package: state encoding, coordinate widths (X_W = 11, Y_W = 10), light-index width.
- One sub-module: light_table (register file with async read, sync write, synchronous clear).

## Test plan
- Fixtures 0,2 enabled ((100,50),(700,400)); frame_done com (320,240); divider done 5 cycles after start -> setup_x_light 100 then 700; result_valid idx 0 then 2; frame_complete once; div_start at t+4.
- All fixtures disabled, frame_done -> frame_complete at t+3, no div_start, no result_valid.
- Two frame_done pulses during processing -> second overwrites pending, overrun = 1; next frame uses last COM.
- cfg write to fixture 1 x = 900 while fixture 1 in DIV_WAIT -> current operands unchanged; next frame shows 900.
- reset asserted in DIV_WAIT -> next cycle IDLE, busy 0, no result_valid even if div_done follows.
- DIV_TIMEOUT_EN, DIV_TIMEOUT = 64, div_done never -> div_error after 64 DIV_WAIT cycles, next fixture proceeds, frame_complete still issued.
